// File: rtl/nn_pkg.sv
// Shared definitions for the neuron sequencer: FSM states, default sizes and
// the register map used by the bus read-back logic.
package nn_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StAccum,
        StAct,
        StDone
    } nn_state_e;

    localparam int unsigned NInputsDefault = 20;
    localparam int unsigned DataWDefault   = 16;
    localparam int unsigned IdxWDefault    = 5;

    localparam logic [11:0] AddrCoeffBase = 12'h100;
    localparam logic [11:0] AddrCoeffLast = 12'h14C;
    localparam logic [11:0] AddrOffset    = 12'h150;
    localparam logic [11:0] AddrInput     = 12'h154;
    localparam logic [11:0] AddrStart     = 12'h158;

endpackage

// File: rtl/nn_accumulator.sv
// Signed accumulator register with load, conditional add and hold.
// Load takes priority over add; with neither asserted the value is held.
module nn_accumulator #(
    parameter int unsigned ACC_W = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             add_i,
    input  logic [ACC_W-1:0] load_val_i,
    input  logic [ACC_W-1:0] add_val_i,
    output logic [ACC_W-1:0] acc_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = load_val_i;
        end else if (add_i) begin
            acc_d = acc_q + add_val_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/neuron_sequencer.sv
// Perceptron evaluation sequencer: snapshot, walk N coefficients, sign activation.
// Optional completion interrupt (irq_o / irq_clear_i) enabled by macro DONE_IRQ_EN.
module neuron_sequencer
    import nn_pkg::*;
#(
    parameter int unsigned N_INPUTS = NInputsDefault,
    parameter int unsigned DATA_W   = DataWDefault,
    parameter int unsigned IDX_W    = IdxWDefault,
    localparam int unsigned ACC_W   = DATA_W + $clog2(N_INPUTS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [N_INPUTS-1:0] input_bits_i,
    input  logic [DATA_W-1:0]   offset_i,
    output logic [IDX_W-1:0]    coeff_index_o,
    input  logic [DATA_W-1:0]   coeff_data_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                result_o,
`ifdef DONE_IRQ_EN
    input  logic                irq_clear_i,
    output logic                irq_o,
`endif
    output logic [ACC_W-1:0]    sum_out_o
);

    nn_state_e           state_q, state_d;
    logic [N_INPUTS-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                result_q, result_d;
    logic [ACC_W-1:0]    sum_q, sum_d;
    logic                acc_load;
    logic                acc_add;
    logic [ACC_W-1:0]    acc;
    logic                idx_last;

    assign idx_last = (idx_q == IDX_W'(N_INPUTS - 1));

    nn_accumulator #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (acc_load),
        .add_i      (acc_add),
        .load_val_i ({{(ACC_W - DATA_W){offset_i[DATA_W-1]}}, offset_i}),
        .add_val_i  ({{(ACC_W - DATA_W){coeff_data_i[DATA_W-1]}}, coeff_data_i}),
        .acc_o      (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            snap_q   <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 1'b0;
            sum_q    <= '0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            sum_q    <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: if (start_i) state_d = StLoad;
            StLoad:         state_d = StAccum;
            StAccum:        if (idx_last) state_d = StAct;
            StAct:          state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    always_comb begin
        snap_d   = snap_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = done_q;
        result_d = result_q;
        sum_d    = sum_q;
        acc_load = 1'b0;
        acc_add  = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    done_d = 1'b0;
                    busy_d = 1'b1;
                end
            end
            StLoad: begin
                snap_d   = input_bits_i;
                acc_load = 1'b1;
                idx_d    = '0;
            end
            StAccum: begin
                acc_add = snap_q[idx_q];
                if (!idx_last) idx_d = idx_q + IDX_W'(1);
            end
            StAct: begin
                sum_d    = acc;
                result_d = ~acc[ACC_W-1];
                busy_d   = 1'b0;
                done_d   = 1'b1;
                idx_d    = '0;
            end
            default: ;
        endcase
    end

`ifdef DONE_IRQ_EN
    logic irq_q, irq_d;

    // Set in ACT wins over a coincident clear; an accepted start also clears.
    always_comb begin
        irq_d = irq_q;
        if (irq_clear_i) irq_d = 1'b0;
        if ((state_q == StIdle || state_q == StDone) && start_i) irq_d = 1'b0;
        if (state_q == StAct) irq_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

    assign coeff_index_o = idx_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign result_o      = result_q;
    assign sum_out_o     = sum_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Self-checking bench for neuron_sequencer: vector table plus corner-case sequences,
// results checked through a scoreboard queue on each Done rising edge.
module tb_neuron_sequencer;

    localparam int N  = 20;
    localparam int DW = 16;
    localparam int IW = 5;
    localparam int AW = 21;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  bits = '0;
    logic [DW-1:0] offset = '0;
    logic [IW-1:0] cidx;
    logic [DW-1:0] cdata;
    logic          busy;
    logic          done;
    logic          result;
    logic [AW-1:0] sum;
`ifdef DONE_IRQ_EN
    logic          irq;
    logic          irq_clear = 1'b0;
`endif

    logic [DW-1:0] coeff [N];
    assign cdata = coeff[cidx];

    neuron_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .input_bits_i  (bits),
        .offset_i      (offset),
        .coeff_index_o (cidx),
        .coeff_data_i  (cdata),
        .busy_o        (busy),
        .done_o        (done),
        .result_o      (result),
`ifdef DONE_IRQ_EN
        .irq_clear_i   (irq_clear),
        .irq_o         (irq),
`endif
        .sum_out_o     (sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        bit res;
    } exp_t;

    typedef struct {
        logic [N-1:0]  b;
        logic [DW-1:0] o;
        int            mode;
        int            sum;
        bit            res;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rise_cnt = 0;
    int   rise_cyc = 0;
    bit   done_prev = 1'b0;
    bit   idx_ok = 1'b1;
    exp_t sb[$];
    vec_t vt[9];

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic exp_t model(logic [N-1:0] b, logic [DW-1:0] o);
        exp_t e;
        int   s;
        s = int'($signed(o));
        for (int i = 0; i < N; i++) begin
            if (b[i]) s += int'($signed(coeff[i]));
        end
        e.sum = s;
        e.res = (s >= 0);
        return e;
    endfunction

    task automatic set_coeffs(input int mode);
        for (int i = 0; i < N; i++) begin
            case (mode)
                1:       coeff[i] = 16'h7FFF;
                2:       coeff[i] = 16'h8000;
                default: coeff[i] = DW'(i + 1);
            endcase
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every Done rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (int'(cidx) >= N) idx_ok = 1'b0;
            if (done && !done_prev) begin
                rise_cnt++;
                rise_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sum_out", int'($signed(sum)), e.sum);
                    chk("result", int'(result), int'(e.res));
                end
            end
            done_prev = done;
        end
    end

    task automatic run_vec(input logic [N-1:0] b, input logic [DW-1:0] o, input exp_t e,
                           input string tag);
        int k;
        int r0;
        int waited;
        bit busy_ok;
        tick();
        bits   = b;
        offset = o;
        start  = 1'b1;
        sb.push_back(e);
        k       = cyc + 1;
        r0      = rise_cnt;
        busy_ok = 1'b1;
        for (int j = 0; j < 22; j++) begin
            tick();
            start = 1'b0;
            if (!busy || done) busy_ok = 1'b0;
        end
        chk({tag, "_busy_window"}, int'(busy_ok), 1);
        waited = 0;
        while (rise_cnt == r0 && waited < 40) begin
            tick();
            waited++;
        end
        if (rise_cnt == r0) begin
            chk({tag, "_done_timeout"}, 0, 1);
        end else begin
            chk({tag, "_latency"}, rise_cyc - k, 22);
            chk({tag, "_busy_after"}, int'(busy), 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   k;
        int   r0;
        int   waited;
        bit   idle_ok;

        vt[0] = '{20'hFFFFF, DW'(-100),  0, 110,     1'b1};
        vt[1] = '{20'hFFFFF, 16'h7FFF,   1, 688107,  1'b1};
        vt[2] = '{20'hFFFFF, 16'h8000,   2, -688128, 1'b0};
        vt[3] = '{20'h00000, 16'h0000,   0, 0,       1'b1};
        vt[4] = '{20'h00000, DW'(37),    0, 37,      1'b1};
        vt[5] = '{20'h00001, DW'(-1),    0, 0,       1'b1};
        vt[6] = '{20'h00001, DW'(-2),    0, -1,      1'b0};
        vt[7] = '{20'h80000, 16'h0000,   0, 20,      1'b1};
        vt[8] = '{20'h0000F, DW'(-50),   0, -40,     1'b0};

        set_coeffs(0);
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_index", int'(cidx), 0);
        rst_n = 1'b1;

        idle_ok = 1'b1;
        repeat (50) begin
            tick();
            if (busy || done || result || sum != '0 || cidx != '0) idle_ok = 1'b0;
        end
        chk("idle_outputs_zero", int'(idle_ok), 1);

        for (int i = 0; i < 9; i++) begin
            set_coeffs(vt[i].mode);
            e.sum = vt[i].sum;
            e.res = vt[i].res;
            run_vec(vt[i].b, vt[i].o, e, $sformatf("vec%0d", i));
        end

        // Snapshot and ignored start while busy.
        set_coeffs(0);
        tick();
        bits   = 20'h000FF;
        offset = DW'(5);
        start  = 1'b1;
        sb.push_back(model(bits, offset));
        k  = cyc + 1;
        r0 = rise_cnt;
        tick();
        start = 1'b0;
        while (cyc < k + 3) tick();
        bits   = 20'hFFFFF;
        offset = DW'(999);
        while (cyc < k + 4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        waited = 0;
        while (rise_cnt == r0 && waited < 40) begin
            tick();
            waited++;
        end
        chk("snap_latency", rise_cyc - k, 22);
        repeat (30) tick();
        chk("snap_single_done", rise_cnt - r0, 1);

        // Asynchronous reset in the middle of ACCUM.
        tick();
        bits   = 20'hFFFFF;
        offset = '0;
        start  = 1'b1;
        sb.push_back(model(bits, offset));
        k = cyc + 1;
        tick();
        start = 1'b0;
        while (cyc < k + 10) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_sum", int'(sum), 0);
        chk("abort_index", int'(cidx), 0);
        void'(sb.pop_back());
        tick();
        rst_n = 1'b1;
        run_vec(20'h00005, DW'(-3), model(20'h00005, DW'(-3)), "post_reset");

        // Start held high: back-to-back complete runs.
        tick();
        bits   = 20'h00003;
        offset = '0;
        start  = 1'b1;
        e = model(bits, offset);
        sb.push_back(e);
        sb.push_back(e);
        k  = cyc + 1;
        r0 = rise_cnt;
        waited = 0;
        while (rise_cnt < r0 + 2 && waited < 80) begin
            tick();
            waited++;
        end
        start = 1'b0;
        chk("b2b_two_runs", rise_cnt - r0, 2);
        chk("b2b_second_done", rise_cyc - k, 45);
        repeat (5) tick();

`ifdef DONE_IRQ_EN
        chk("irq_after_b2b", int'(irq), 1);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        chk("irq_cleared", int'(irq), 0);
        tick();
        bits   = 20'h00001;
        offset = '0;
        start  = 1'b1;
        sb.push_back(model(bits, offset));
        k = cyc + 1;
        tick();
        start = 1'b0;
        while (cyc < k + 21) tick();
        chk("irq_before_act", int'(irq), 0);
        irq_clear = 1'b1;
        tick();
        chk("irq_set_wins", int'(irq), 1);
        chk("irq_with_done", int'(done), 1);
        irq_clear = 1'b0;
        tick();
        chk("irq_held", int'(irq), 1);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        chk("irq_clear_after", int'(irq), 0);
        repeat (3) tick();
`endif

        chk("index_range", int'(idx_ok), 1);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_sequencer.md
Name: neuron_sequencer

Overview:
- Sequences one perceptron evaluation over the memory-mapped coefficient, offset and input registers.
- On a start request it takes a snapshot of the input vector and the offset.
- It then walks the N coefficient registers one per cycle through an index/data fetch port, accumulating offset + sum(x_i * w_i).
- It applies a sign activation and presents the result and status to the bus read-back logic.

Parameters:
- N_INPUTS, 20: number of coefficient registers and input bits.
- DATA_W, 16: width of coefficient and offset words, signed two's complement.
- IDX_W, 5: width of the coefficient index; must satisfy 2**IDX_W >= N_INPUTS.
- Localparam ACC_W = DATA_W + $clog2(N_INPUTS+1): the accumulator width. With this width no overflow is possible.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  start request, qualified by the bus write to the start address; acted on only in IDLE or DONE.
- InputBits  in  N_INPUTS  contents of the input register; bit i is x_i.
- Offset  in  DATA_W  contents of the offset coefficient register, signed.
- CoeffIndex  out  IDX_W  registered index selecting coefficient register w_i.
- CoeffData  in  DATA_W  selected coefficient, combinational from CoeffIndex, valid in the same cycle, signed.
- Busy  out  1  high while a run is active; the bus logic uses it to block coefficient writes.
- Done  out  1  sticky completion flag; cleared by the next accepted Start.
- Result  out  1  activation output: 1 if the final sum is >= 0, else 0.
- SumOut  out  ACC_W  final signed accumulator value.

Behaviour:
- Reset values: Busy=0, Done=0, Result=0, SumOut=0, CoeffIndex=0, state IDLE.
- FSM states: IDLE, LOAD, ACCUM, ACT, DONE.
- IDLE/DONE: Start=1 is accepted. Transition to LOAD; Done<=0; Busy<=1.
- LOAD (1 cycle):
  - snap<=InputBits
  - acc<=sign-extended Offset
  - CoeffIndex<=0
  - transition to ACCUM
- ACCUM (exactly N_INPUTS cycles):
  - each cycle, if snap[CoeffIndex]=1 then acc<=acc+sign-extended CoeffData, else acc unchanged.
  - if CoeffIndex==N_INPUTS-1, transition to ACT (no increment); otherwise CoeffIndex+1.
- ACT (1 cycle):
  - SumOut<=acc
  - Result<=~acc[ACC_W-1]
  - Busy<=0
  - Done<=1
  - CoeffIndex<=0
  - transition to DONE
- DONE: hold all outputs until Start is accepted again.
- Latency: Start is sampled at edge k; Done and Result are visible after edge k+N_INPUTS+2 (22 for the default N_INPUTS).
- Start while Busy=1 is ignored: no restart, no queueing.
- Start held high continuously: a new run begins on the cycle after DONE is entered. Each run still completes fully.
- InputBits/Offset changes after LOAD have no effect on the current run because they are snapshotted.
- CoeffData changes during ACCUM are used as presented; blocking such writes via Busy is the bus logic's responsibility.
- Index wrap: CoeffIndex never exceeds N_INPUTS-1; values N_INPUTS..2**IDX_W-1 never appear.
- Reset_n asserted mid-run: immediate abort to the reset values above; no partial result is kept.
- All-zero InputBits: SumOut=Offset. Offset=0 with zero sum: Result=1 (>= 0 rule).

Optional Feature:
- Macro DONE_IRQ_EN.
- When defined: adds port Irq (out, 1) and port IrqClear (in, 1).
  - Irq is set in the ACT cycle and held until IrqClear=1 or an accepted Start.
  - If set and clear coincide, set wins.
  - Irq reset value is 0.
- When undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Shared package nn_pkg holds:
  - the FSM state enum (IDLE, LOAD, ACCUM, ACT, DONE)
  - default N_INPUTS/DATA_W constants
  - the register address constants (coefficients 0x100-0x14C, offset 0x150, input 0x154, start 0x158)
- One natural sub-module: nn_accumulator, the signed ACC_W adder/register with load, conditional-add and hold controls. The FSM and index counter stay in neuron_sequencer.

Test Plan:
- Reset release with no Start: all outputs stay 0 for 50 cycles; CoeffIndex=0.
- Coefficients w_i=i+1, Offset=-100, InputBits=0xFFFFF, pulse Start: expect SumOut=110, Result=1, Done high at exactly k+22, Busy high k+1..k+21.
- All w_i=0x7FFF, Offset=0x7FFF, InputBits all ones: expect SumOut=21*32767=688107 with no wrap. Then set all w_i=0x8000, Offset=0x8000: expect SumOut=-688128, Result=0.
- Start pulse at cycle k+5 of a run, and InputBits changed at k+3: run unaffected; SumOut matches the snapshot value; exactly one Done rising edge.
- Reset_n low at ACCUM cycle 10: outputs return to reset values asynchronously. After a new Start, the result is correct for fresh data.
- With DONE_IRQ_EN: Irq rises with Done and is cleared by IrqClear. IrqClear coincident with an ACT cycle: Irq stays 1.
